// File: rtl/offset_collect_stage_pkg.sv
// Shared types and default sizes for the offset collect stage and its expected-sequence counter.
package offset_collect_stage_pkg;

  localparam int OC_BW     = 8;
  localparam int OC_DIM    = 2;
  localparam int OC_CNT_BW = 16;

  typedef enum logic [1:0] {OC_IDLE, OC_RUN, OC_DONE} oc_state_e;

  typedef logic [OC_BW-1:0] oc_ofs_t;

endpackage

// File: rtl/offset_collect_stage_nd_expect_counter.sv
// Regenerates the N-D offset sequence of one range; dim DIM-1 is innermost.
// exp_last flags the beat on which every dim would carry.
module nd_expect_counter
  import offset_collect_stage_pkg::*;
#(
  parameter int BW  = OC_BW,
  parameter int DIM = OC_DIM
) (
  input  logic                    i_clk,
  input  logic                    i_restart,
  input  logic                    i_step,
  input  logic [DIM-1:0][BW-1:0]  i_beg,
  input  logic [DIM-1:0][BW-1:0]  i_end,
  input  logic [DIM-1:0][BW-1:0]  i_stride,
  output logic [DIM-1:0][BW-1:0]  o_exp,
  output logic                    o_exp_last
);

  logic [DIM-1:0][BW-1:0] r_beg;
  logic [DIM-1:0][BW-1:0] r_end;
  logic [DIM-1:0][BW-1:0] r_stride;
  logic [DIM-1:0][BW-1:0] r_exp;
  logic [DIM-1:0][BW-1:0] w_sum;
  logic [DIM-1:0][BW-1:0] w_nxt;
  logic [DIM-1:0]         w_wrap;
  logic [DIM-1:0]         w_adv;

  // An empty dim (end<=beg) or zero stride pins the dim at beg and always carries.
  always_comb begin
    w_sum  = '0;
    w_nxt  = '0;
    w_wrap = '0;
    w_adv  = '0;
    for (int d = 0; d < DIM; d++) begin
      w_sum[d]  = r_exp[d] + r_stride[d];
      w_wrap[d] = (r_end[d] <= r_beg[d]) || (r_stride[d] == '0) || (w_sum[d] >= r_end[d]);
      w_nxt[d]  = w_wrap[d] ? r_beg[d] : w_sum[d];
    end
    w_adv[DIM-1] = 1'b1;
    for (int d = DIM-2; d >= 0; d--) begin
      w_adv[d] = w_adv[d+1] && w_wrap[d+1];
    end
  end

  assign o_exp      = r_exp;
  assign o_exp_last = w_adv[0] && w_wrap[0];

  always_ff @(posedge i_clk) begin
    if (i_restart) begin
      r_beg    <= i_beg;
      r_end    <= i_end;
      r_stride <= i_stride;
      r_exp    <= i_beg;
    end else if (i_step) begin
      for (int d = 0; d < DIM; d++) begin
        if (w_adv[d]) r_exp[d] <= w_nxt[d];
      end
    end
  end

endmodule

// File: rtl/offset_collect_stage.sv
// Terminates an N-D offset beat stream: counts beats per range and emits one summary.
// Define OFFSET_COLLECT_CHECK_EN to compare each beat against the regenerated expected sequence.
module offset_collect_stage
  import offset_collect_stage_pkg::*;
#(
  parameter int BW     = OC_BW,
  parameter int DIM    = OC_DIM,
  parameter int CNT_BW = OC_CNT_BW
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    cfg_rdy,
  output logic                    cfg_ack,
  input  logic [DIM-1:0][BW-1:0]  i_ofs_beg,
  input  logic [DIM-1:0][BW-1:0]  i_ofs_end,
  input  logic [DIM-1:0][BW-1:0]  i_stride,
  input  logic                    src_rdy,
  output logic                    src_ack,
  input  logic [DIM-1:0][BW-1:0]  i_ofs,
  input  logic                    i_islast,
  output logic                    dst_rdy,
  input  logic                    dst_ack,
  output logic [CNT_BW-1:0]       o_count,
  output logic [DIM-1:0][BW-1:0]  o_last_ofs,
  output logic                    o_err
);

  oc_state_e              r_state;
  logic [CNT_BW-1:0]      r_count;
  logic [DIM-1:0][BW-1:0] r_last_ofs;

  function automatic logic [CNT_BW-1:0] sat_inc(input logic [CNT_BW-1:0] v);
    return (&v) ? v : v + CNT_BW'(1);
  endfunction

  assign cfg_ack    = cfg_rdy && (r_state == OC_IDLE);
  assign src_ack    = src_rdy && (r_state == OC_RUN);
  assign dst_rdy    = (r_state == OC_DONE);
  assign o_count    = r_count;
  assign o_last_ofs = r_last_ofs;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state    <= OC_IDLE;
      r_count    <= '0;
      r_last_ofs <= '0;
    end else begin
      case (r_state)
        OC_IDLE: if (cfg_rdy) begin
          r_state    <= OC_RUN;
          r_count    <= '0;
          r_last_ofs <= '0;
        end
        OC_RUN: if (src_rdy) begin
          r_count    <= sat_inc(r_count);
          r_last_ofs <= i_ofs;
          if (i_islast) r_state <= OC_DONE;
        end
        OC_DONE: if (dst_ack) r_state <= OC_IDLE;
        default: r_state <= OC_IDLE;
      endcase
    end
  end

`ifdef OFFSET_COLLECT_CHECK_EN
  logic [DIM-1:0][BW-1:0] w_exp;
  logic                   w_exp_last;
  logic                   w_bad;
  logic                   r_err;

  nd_expect_counter #(.BW(BW), .DIM(DIM)) u_expect (
    .i_clk      (i_clk),
    .i_restart  (cfg_ack),
    .i_step     (src_ack),
    .i_beg      (i_ofs_beg),
    .i_end      (i_ofs_end),
    .i_stride   (i_stride),
    .o_exp      (w_exp),
    .o_exp_last (w_exp_last)
  );

  assign w_bad = (i_ofs != w_exp) || (i_islast != w_exp_last);
  assign o_err = r_err;

  // Sticky for the whole range; cleared only when the next descriptor is taken.
  always_ff @(posedge i_clk) begin
    if (!i_rst)       r_err <= 1'b0;
    else if (cfg_ack) r_err <= 1'b0;
    else if (src_ack && w_bad) r_err <= 1'b1;
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{i_ofs_beg, i_ofs_end, i_stride};
  assign o_err = 1'b0;
`endif

endmodule
